// File: rtl/tremolo_mod.sv
// rtl/tremolo_mod.sv - tremolo gain stage driven by a triangle LFO
//
// Purpose: steps the LFO at a programmable rate and scales each audio
// sample by g = 2^N - ((depth*wav) >> N) using sequential shift-add
// multipliers, with valid/ready handshakes on both audio sides.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   en                effect enable (0 = bypass, rate counter idle)
//   rate              clocks per LFO step
//   depth             modulation depth (unsigned, N bits)
//   nxt               single-cycle LFO advance pulse
//   wav               LFO wave value (unsigned, N bits)
//   s_valid/s_ready/s_data   input sample stream (signed DW bits)
//   m_valid/m_ready/m_data   output sample stream (signed DW bits)
module tremolo_mod #(
  parameter int DW = 16,
  parameter int N  = 8,
  parameter int RW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [RW-1:0] rate,
  input  logic [N-1:0]  depth,
  output logic          nxt,
  input  logic [N-1:0]  wav,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);

  localparam int PW = DW + N + 1;
  localparam int CW = $clog2(N + 1) + 1;
  localparam logic [N:0] UNITY = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {IDLE, GAIN, SAMP, OUT} state_t;

  // ---------------------------------------------------------------------
  // Rate divider. The pulse cycle always forces the counter back to 0, so
  // nxt can never be high on two consecutive cycles.
  // ---------------------------------------------------------------------
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          nxt_q, nxt_d;

  always_comb begin
    rcnt_d = '0;
    nxt_d  = 1'b0;
    if (en && rate >= RW'(2)) begin
      // >= rather than == so a rate lowered below the count wraps at once
      if (rcnt_q >= rate - RW'(1)) begin
        nxt_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      nxt_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      nxt_q  <= nxt_d;
    end
  end

  assign nxt = nxt_q;

  // ---------------------------------------------------------------------
  // Sample path. wav/depth/en/s_data are snapshotted at the handshake
  // directly into the multiplier shift registers.
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_q, en_d;
  logic [N-1:0]    wsh_q, wsh_d;     // multiplier bits of wav, LSB first
  logic [2*N-1:0]  pmc_q, pmc_d;     // depth, shifted left each step
  logic [2*N-1:0]  p_q, p_d;         // depth*wav accumulator
  logic [N:0]      gsh_q, gsh_d;     // gain bits, LSB first
  logic [PW-1:0]   smc_q, smc_d;     // sign-extended sample, shifted left
  logic [PW-1:0]   acc_q, acc_d;     // sample*gain accumulator
  logic [DW-1:0]   mdata_q, mdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    wsh_d   = wsh_q;
    pmc_d   = pmc_q;
    p_d     = p_q;
    gsh_d   = gsh_q;
    smc_d   = smc_q;
    acc_d   = acc_q;
    mdata_d = mdata_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          wsh_d   = wav;
          pmc_d   = {{N{1'b0}}, depth};
          p_d     = '0;
          en_d    = en;
          smc_d   = {{(N + 1){s_data[DW-1]}}, s_data};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = GAIN;
        end
      end
      GAIN: begin
        if (wsh_q[0]) p_d = p_q + pmc_q;
        pmc_d = pmc_q << 1;
        wsh_d = wsh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // bypass forces unity gain so the sample passes through unchanged
          gsh_d   = en_q ? (UNITY - {1'b0, p_d[2*N-1:N]}) : UNITY;
          cnt_d   = '0;
          state_d = SAMP;
        end
      end
      SAMP: begin
        // gain is unsigned, so every partial product is a plain add of the
        // sign-extended sample; no correction term for the top bit
        if (gsh_q[0]) acc_d = acc_q + smc_q;
        smc_d = smc_q << 1;
        gsh_d = gsh_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N)) begin
          // taking bits [N +: DW] is the floor shift by N plus truncation
          mdata_d = acc_d[N +: DW];
          state_d = OUT;
        end
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      wsh_q   <= '0;
      pmc_q   <= '0;
      p_q     <= '0;
      gsh_q   <= '0;
      smc_q   <= '0;
      acc_q   <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      wsh_q   <= wsh_d;
      pmc_q   <= pmc_d;
      p_q     <= p_d;
      gsh_q   <= gsh_d;
      smc_q   <= smc_d;
      acc_q   <= acc_d;
      mdata_q <= mdata_d;
    end
  end

  // no bypass path: a new sample is only taken from IDLE
  assign s_ready = (state_q == IDLE);
  assign m_valid = (state_q == OUT);
  assign m_data  = mdata_q;

endmodule

// File: tb/tb_tremolo_mod.sv
// tb/tb_tremolo_mod.sv - directed self-checking bench for tremolo_mod
module tb_tremolo_mod;

  localparam int DW = 16;
  localparam int N  = 8;
  localparam int RW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [RW-1:0] rate = '0;
  logic [N-1:0]  depth = '0;
  logic          nxt;
  logic [N-1:0]  wav = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tremolo_mod #(.DW(DW), .N(N), .RW(RW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .rate    (rate),
    .depth   (depth),
    .nxt     (nxt),
    .wav     (wav),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One full sample: handshake, wait for result, optional backpressure,
  // single transfer. wiggle scrambles wav/depth/en while computing.
  task automatic do_sample(input string tag, input int sv, input int dp,
                           input int wv, input logic e, input bit wiggle,
                           input int hold, input int exp);
    int lat;
    bit stable;
    logic [DW-1:0] held;
    @(negedge clk);
    check({tag, "_s_ready_idle"}, int'(s_ready), 1);
    s_data  = DW'(sv);
    depth   = N'(dp);
    wav     = N'(wv);
    en      = e;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    lat = 0;
    while (!m_valid && lat < 100) begin
      if (wiggle) begin
        wav   = N'($urandom);
        depth = N'($urandom);
        en    = ~en;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 2 * N + 1);
    check({tag, "_result"}, int'($signed(m_data)), exp);
    if (hold > 0) begin
      stable = 1'b1;
      held = m_data;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (!m_valid || m_data !== held || s_ready) stable = 1'b0;
      end
      check({tag, "_hold_stable"}, int'(stable), 1);
    end
    @(negedge clk);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check({tag, "_m_valid_drop"}, int'(m_valid), 0);
    check({tag, "_s_ready_back"}, int'(s_ready), 1);
  endtask

  initial begin
    int n;
    int pulses;
    int bad;
    logic [5:0] pat;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_nxt", int'(nxt), 0);
    rst_n = 1'b1;

    do_sample("g128",  1000,   128, 128, 1'b1, 1'b0, 0, 750);
    do_sample("g255p", 1000,   255, 255, 1'b1, 1'b0, 0, 7);
    do_sample("g255n", -1000,  255, 255, 1'b1, 1'b0, 0, -8);
    do_sample("d0",    -32768, 0,   173, 1'b1, 1'b0, 0, -32768);
    do_sample("byp",   12345,  255, 255, 1'b0, 1'b1, 0, 12345);
    do_sample("snap",  1000,   128, 128, 1'b1, 1'b1, 0, 750);
    do_sample("bp",    -5000,  64,  200, 1'b1, 1'b0, 10, -4024);

    // rate=4: find a pulse, then expect one every 4th edge
    @(negedge clk);
    en = 1'b1;
    rate = RW'(4);
    n = 0;
    while (!nxt && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("r4_first_pulse_seen", int'(nxt), 1);
    pulses = 0;
    bad = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      #1;
      if (nxt) pulses++;
      if (nxt != ((j % 4) == 0)) bad++;
    end
    check("r4_pulses", pulses, 10);
    check("r4_phase_errors", bad, 0);

    rate = RW'(1);
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (nxt) pulses++;
    end
    check("r1_pulses", pulses, 0);

    rate = RW'(4);
    en = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (nxt) pulses++;
    end
    check("en0_pulses", pulses, 0);

    // rate 100 -> 3 at count 50
    en = 1'b1;
    rate = RW'(100);
    n = 0;
    while (!nxt && n < 250) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("r100_pulse_seen", int'(nxt), 1);
    pulses = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (nxt) pulses++;
    end
    check("r100_no_early_pulse", pulses, 0);
    rate = RW'(3);
    for (int j = 0; j < 6; j++) begin
      @(posedge clk);
      #1;
      pat[j] = nxt;
    end
    check("r100to3_pattern", int'(pat), int'(6'b001001));

    // reset in the middle of a computation
    @(negedge clk);
    rate = RW'(4);
    s_data = DW'(1000);
    depth = N'(128);
    wav = N'(128);
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_m_valid", int'(m_valid), 0);
    check("mid_rst_m_data", int'(m_data), 0);
    check("mid_rst_s_ready", int'(s_ready), 1);
    check("mid_rst_nxt", int'(nxt), 0);
    rate = '0;
    do_sample("post_rst", 1000, 255, 255, 1'b1, 1'b0, 0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
